// File: rtl/debouncer_pkg.sv
// Shared constants for the debouncer bank: debounce mode encodings and counter sizing.
package debouncer_pkg;

   localparam int MODE_LOCKOUT   = 0;
   localparam int MODE_INTEGRATE = 1;

   // Counter must hold 0..CLK_WAIT without wrapping; never narrower than one bit.
   function automatic int cnt_width(input int wait_cycles);
      return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: optional 2-flop synchroniser (DEBOUNCER_BANK_SYNC_EN), interval counter,
// debounced level, registered rise/fall pulses and busy flag, in LOCKOUT or INTEGRATE mode.
module debounce_channel
   import debouncer_pkg::*;
#(
   parameter int CLK_WAIT = 30000000,
   parameter int MODE     = MODE_LOCKOUT,
   parameter bit INIT     = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_button,
   output logic o_signal,
   output logic o_rise,
   output logic o_fall,
   output logic o_busy
);

   localparam int            CW       = cnt_width(CLK_WAIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_WAIT - 1);

   logic          s;
   logic [CW-1:0] count;
   logic [CW-1:0] count_d;
   logic          sig_d;
   logic          busy_d;
   logic          level_q;

`ifdef DEBOUNCER_BANK_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) sync_q <= {2{INIT}};
      else       sync_q <= {sync_q[0], i_button};
   end

   assign s = sync_q[1];
`else
   assign s = i_button;
`endif

   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
      sig_d   = o_signal;
      busy_d  = o_busy;
      count_d = count;
      if (MODE == MODE_INTEGRATE) begin
         if (s == o_signal) begin
            busy_d  = 1'b0;
            count_d = '0;
         end else if (count == CNT_LAST) begin
            sig_d   = s;
            busy_d  = 1'b0;
            count_d = '0;
         end else begin
            busy_d  = 1'b1;
            count_d = count + 1'b1;
         end
      end else begin
         // Lockout: take the new level at once, then ignore the input for CLK_WAIT cycles.
         if (o_busy) begin
            if (count == CNT_LAST) begin
               busy_d  = 1'b0;
               count_d = '0;
            end else begin
               count_d = count + 1'b1;
            end
         end else if (s != o_signal) begin
            sig_d   = s;
            busy_d  = 1'b1;
            count_d = '0;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
      if (i_rst) begin
         o_signal <= INIT;
         o_busy   <= 1'b0;
         count    <= '0;
         level_q  <= INIT;
         o_rise   <= 1'b0;
         o_fall   <= 1'b0;
      end else begin
         o_signal <= sig_d;
         o_busy   <= busy_d;
         count    <= count_d;
         level_q  <= o_signal;
         o_rise   <= o_signal & ~level_q;
         o_fall   <= ~o_signal & level_q;
      end
   end

endmodule

// File: rtl/debouncer_bank.sv
// Bank of CHANNELS independent debouncers; DEBOUNCER_BANK_SYNC_EN adds a 2-flop input synchroniser per channel.
module debouncer_bank
   import debouncer_pkg::*;
#(
   parameter int CHANNELS = 8,
   parameter int CLK_WAIT = 30000000,
   parameter int MODE     = MODE_LOCKOUT,
   parameter bit INIT     = 1'b0
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [CHANNELS-1:0] i_button,
   output logic [CHANNELS-1:0] o_signal,
   output logic [CHANNELS-1:0] o_rise,
   output logic [CHANNELS-1:0] o_fall,
   output logic [CHANNELS-1:0] o_busy
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      debounce_channel #(
         .CLK_WAIT(CLK_WAIT),
         .MODE    (MODE),
         .INIT    (INIT)
      ) u_ch (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_button(i_button[i]),
         .o_signal(o_signal[i]),
         .o_rise  (o_rise[i]),
         .o_fall  (o_fall[i]),
         .o_busy  (o_busy[i])
      );
   end

endmodule
